// File: rtl/sram_ctrl_pkg.sv
// Shared types and default timing for the CY6264 SRAM sequencer.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_TURN = 3'd2,
        ST_WSU  = 3'd3,
        ST_WP   = 3'd4,
        ST_WH   = 3'd5
    } state_t;

    localparam int CNT_W            = 4;
    localparam int DEF_READ_CYCLES  = 3;
    localparam int DEF_WRITE_CYCLES = 3;
    localparam int DEF_TURN_CYCLES  = 1;
    localparam int DEF_AW           = 13;
    localparam int DEF_DW           = 8;

    // Phase counters count down from n-1 and the phase ends at zero.
    function automatic logic [CNT_W-1:0] cnt_load(input int n);
        return (n > 0) ? CNT_W'(n - 1) : '0;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin arbiter; masked ports are ignored, pointer advances on each taken grant.
module sram_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       take,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    logic       ptr;
    logic [1:0] eff;

    always_comb begin
        eff       = req & ~mask;
        gnt_valid = |eff;
        // ptr names the preferred port when both contend
        if (&eff) gnt_idx = ptr;
        else      gnt_idx = eff[1];
    end

    always_ff @(posedge clk) begin
        if (rst)                    ptr <= 1'b0;
        else if (take && gnt_valid) ptr <= ~gnt_idx;
    end

endmodule

// File: rtl/sram6264_arbiter.sv
// Two-port round-robin sequencer for one 8Kx8 asynchronous SRAM with programmable wait states.
// state | meaning
// IDLE  | strobes high, bus released, arbitration   RD   | nCE1/nOE low, sample on last cycle
// TURN  | bus turnaround after a read               WSU  | address/data setup, nWE high
// WP    | nWE low write pulse                       WH   | data hold, nWE high, then ACK
module sram6264_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int READ_CYCLES  = DEF_READ_CYCLES,
    parameter int WRITE_CYCLES = DEF_WRITE_CYCLES,
    parameter int TURN_CYCLES  = DEF_TURN_CYCLES,
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA0,
    output logic [DW-1:0] RDATA1,
    output logic          SRAM_nCE1,
    output logic          SRAM_CE2,
    output logic          SRAM_nOE,
    output logic          SRAM_nWE,
    output logic [AW-1:0] SRAM_A,
    output logic [DW-1:0] SRAM_D_O,
    output logic          SRAM_D_OE,
    input  logic [DW-1:0] SRAM_D_I
);

    localparam logic [CNT_W-1:0] RD_LOAD   = cnt_load(READ_CYCLES);
    localparam logic [CNT_W-1:0] WR_LOAD   = cnt_load(WRITE_CYCLES);
    localparam logic [CNT_W-1:0] TURN_LOAD = cnt_load(TURN_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             gnt_idx, gnt_valid;
    logic             we_sel, rd_done, ack_now;
    logic             ce_active, oe_active;

    sram_rr_arbiter u_arb (
        .clk       (CLK),
        .rst       (RST),
        .req       ({REQ1, REQ0}),
        .mask      ({ACK1, ACK0}),
        .take      (state_q == ST_IDLE),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_sel  = gnt_idx ? WE1 : WE0;
        rd_done = 1'b0;
        ack_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    sel_d   = gnt_idx;
                    addr_d  = gnt_idx ? ADDR1 : ADDR0;
                    wdata_d = gnt_idx ? WDATA1 : WDATA0;
                    if (we_sel) begin
                        state_d = ST_WSU;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_RD;
                        cnt_d   = RD_LOAD;
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == '0) begin
                    rd_done = 1'b1;
                    ack_now = 1'b1;
                    state_d = (TURN_CYCLES > 0) ? ST_TURN : ST_IDLE;
                    cnt_d   = TURN_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_WSU: begin
                state_d = ST_WP;
                cnt_d   = WR_LOAD;
            end
            ST_WP: begin
                if (cnt_q == '0) state_d = ST_WH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_WH: begin
                ack_now = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // strobes are registered from the next state so they align with it
        ce_active = (state_d == ST_RD) || (state_d == ST_WSU) ||
                    (state_d == ST_WP) || (state_d == ST_WH);
        oe_active = (state_d == ST_WSU) || (state_d == ST_WP) || (state_d == ST_WH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ACK0      <= 1'b0;
            ACK1      <= 1'b0;
            RDATA0    <= '0;
            RDATA1    <= '0;
            SRAM_nCE1 <= 1'b1;
            SRAM_CE2  <= 1'b1;
            SRAM_nOE  <= 1'b1;
            SRAM_nWE  <= 1'b1;
            SRAM_A    <= '0;
            SRAM_D_O  <= '0;
            SRAM_D_OE <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ACK0      <= ack_now && !sel_q;
            ACK1      <= ack_now && sel_q;
            if (rd_done && !sel_q) RDATA0 <= SRAM_D_I;
            if (rd_done && sel_q)  RDATA1 <= SRAM_D_I;
            SRAM_nCE1 <= !ce_active;
            SRAM_CE2  <= 1'b1;
            SRAM_nOE  <= (state_d != ST_RD);
            SRAM_nWE  <= (state_d != ST_WP);
            SRAM_A    <= addr_d;
            SRAM_D_O  <= wdata_d;
            SRAM_D_OE <= oe_active;
        end
    end

endmodule

// File: tb/tb_sram6264_arbiter.sv
// Bench for sram6264_arbiter: directed steps plus random traffic against an SRAM model and scoreboard.
`timescale 1ns/1ps
module tb_sram6264_arbiter;

    localparam int RC = 3;
    localparam int WC = 3;
    localparam int TC = 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
    logic [12:0] ADDR0 = '0, ADDR1 = '0;
    logic [7:0]  WDATA0 = '0, WDATA1 = '0;
    logic        ACK0, ACK1;
    logic [7:0]  RDATA0, RDATA1;
    logic        SRAM_nCE1, SRAM_CE2, SRAM_nOE, SRAM_nWE, SRAM_D_OE;
    logic [12:0] SRAM_A;
    logic [7:0]  SRAM_D_O, SRAM_D_I;

    logic [7:0]  mem [0:8191];
    logic [7:0]  ref_mem [0:8191];
    bit          ref_valid [0:8191];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_conflict = 0;

    always #16.667 CLK = ~CLK;

    sram6264_arbiter #(
        .READ_CYCLES(RC), .WRITE_CYCLES(WC), .TURN_CYCLES(TC), .AW(13), .DW(8)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
        .SRAM_nCE1(SRAM_nCE1), .SRAM_CE2(SRAM_CE2), .SRAM_nOE(SRAM_nOE),
        .SRAM_nWE(SRAM_nWE), .SRAM_A(SRAM_A), .SRAM_D_O(SRAM_D_O),
        .SRAM_D_OE(SRAM_D_OE), .SRAM_D_I(SRAM_D_I)
    );

    // CY6264-style part: drives data while selected and output-enabled, writes while nWE low
    assign SRAM_D_I = (!SRAM_nCE1 && SRAM_CE2 && !SRAM_nOE && SRAM_nWE) ? mem[SRAM_A] : 8'hzz;

    always @(negedge CLK) begin
        if (!SRAM_nWE && !SRAM_nCE1 && SRAM_CE2 && SRAM_D_OE) mem[SRAM_A] <= SRAM_D_O;
        if ((!SRAM_nOE && SRAM_D_OE) || (!SRAM_nWE && !SRAM_D_OE)) n_conflict <= n_conflict + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int p, input bit req, input bit we,
                         input logic [12:0] a, input logic [7:0] d);
        if (p == 0) begin REQ0 = req; WE0 = we; ADDR0 = a; WDATA0 = d; end
        else        begin REQ1 = req; WE1 = we; ADDR1 = a; WDATA1 = d; end
    endtask

    // One transaction from the issuing cycle to its ACK; collects strobe statistics.
    task automatic txn_check(input int p, input bit we, input logic [12:0] a,
                             input logic [7:0] d, input int extra);
        int lat, n_oe, n_we, n_doe, first_we, bad_a, bad_do;
        bit got;
        logic [7:0] rd;
        lat = -1; n_oe = 0; n_we = 0; n_doe = 0; first_we = 0; bad_a = 0; bad_do = 0;
        got = 1'b0; rd = '0;
        drive(p, 1'b1, we, a, d);
        for (int c = 1; c <= 40 && !got; c++) begin
            tick();
            if (!SRAM_nOE) n_oe++;
            if (!SRAM_nWE) begin n_we++; if (first_we == 0) first_we = c; end
            if (SRAM_D_OE) begin n_doe++; if (SRAM_D_O !== d) bad_do++; end
            if (!SRAM_nCE1 && SRAM_A !== a) bad_a++;
            if ((p == 0) ? ACK0 : ACK1) begin
                got = 1'b1;
                lat = c;
                rd = (p == 0) ? RDATA0 : RDATA1;
            end
        end
        drive(p, 1'b0, we, a, d);
        chk(we ? "wr_latency" : "rd_latency", 32'(lat), 32'((we ? WC + 3 : RC + 1) + extra));
        chk("noe_cycles", 32'(n_oe), 32'(we ? 0 : RC));
        chk("nwe_cycles", 32'(n_we), 32'(we ? WC : 0));
        chk("doe_cycles", 32'(n_doe), 32'(we ? WC + 2 : 0));
        chk("addr_stable", 32'(bad_a), 32'd0);
        if (we) begin
            chk("nwe_first_cycle", 32'(first_we - extra), 32'd2);
            chk("do_stable", 32'(bad_do), 32'd0);
            ref_mem[a] = d;
            ref_valid[a] = 1'b1;
        end else if (ref_valid[a]) begin
            chk("rdata", 32'(rd), 32'(ref_mem[a]));
        end
    endtask

    initial begin
        int got, lat, acks;
        int order [$];
        logic [12:0] a;

        // reset held with both requests high
        RST = 1'b1;
        drive(0, 1'b1, 1'b0, 13'h0010, 8'h00);
        drive(1, 1'b1, 1'b1, 13'h0020, 8'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_strobes", {28'd0, SRAM_nCE1, SRAM_nOE, SRAM_nWE, SRAM_CE2}, 32'hF);
            chk("rst_doe_ack", {29'd0, SRAM_D_OE, ACK0, ACK1}, 32'd0);
            chk("rst_a_rdata", {SRAM_A, 3'd0, RDATA0, RDATA1}, 32'd0);
        end
        drive(0, 1'b0, 1'b0, 13'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 13'h0, 8'h0);
        RST = 1'b0;
        tick();

        // single write, then read-back of a written pattern
        txn_check(1, 1'b1, 13'h0001, 8'hC3, 0);
        tick();
        txn_check(1, 1'b1, 13'h1ABC, 8'h5A, 0);
        tick();
        txn_check(0, 1'b0, 13'h1ABC, 8'h00, 0);
        // write issued in the read's ACK cycle waits out the turnaround
        txn_check(1, 1'b1, 13'h0002, 8'h3C, TC);
        // read on the other port in the write's ACK cycle needs no gap
        txn_check(0, 1'b0, 13'h0001, 8'h00, 0);
        chk("ce2_const", 32'(SRAM_CE2), 32'd1);
        tick();

        // integration write/read at 0x0FFF
        txn_check(0, 1'b1, 13'h0FFF, 8'hA5, 0);
        tick();
        txn_check(1, 1'b0, 13'h0FFF, 8'h00, 0);
        tick();

        // request dropped and qualifiers changed after grant
        drive(1, 1'b1, 1'b0, 13'h0FFF, 8'h00);
        tick();
        drive(1, 1'b0, 1'b1, 13'h0222, 8'hEE);
        got = 0; lat = -1;
        for (int c = 2; c <= 30 && got == 0; c++) begin
            tick();
            if (ACK1) begin got = 1; lat = c; end
        end
        chk("drop_latency", 32'(lat), 32'(RC + 1));
        chk("drop_rdata", 32'(RDATA1), 32'h00A5);
        tick();
        tick();
        chk("drop_no_write", 32'(mem[13'h0222] === 8'hEE), 32'd0);

        // contention from reset: strict alternation starting at port 0
        RST = 1'b1;
        tick();
        tick();
        drive(0, 1'b1, 1'b0, 13'h1ABC, 8'h00);
        drive(1, 1'b1, 1'b0, 13'h0001, 8'h00);
        RST = 1'b0;
        for (int c = 0; c < 100 && order.size() < 6; c++) begin
            tick();
            if (ACK0) begin
                order.push_back(0);
                chk("cont_rdata0", 32'(RDATA0), 32'(ref_mem[13'h1ABC]));
            end
            if (ACK1) begin
                order.push_back(1);
                chk("cont_rdata1", 32'(RDATA1), 32'(ref_mem[13'h0001]));
            end
        end
        drive(0, 1'b0, 1'b0, 13'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 13'h0, 8'h0);
        chk("cont_ack_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < order.size(); i++) chk("cont_order", 32'(order[i]), 32'(i % 2));
        tick();
        tick();

        // reset during the write pulse
        drive(0, 1'b1, 1'b1, 13'h0100, 8'h77);
        tick();
        tick();
        chk("wp_nwe_low", 32'(SRAM_nWE), 32'd0);
        RST = 1'b1;
        tick();
        chk("midrst_strobes", {29'd0, SRAM_nWE, SRAM_nCE1, SRAM_D_OE}, 32'h6);
        chk("midrst_ack", {30'd0, ACK0, ACK1}, 32'd0);
        RST = 1'b0;
        drive(0, 1'b0, 1'b0, 13'h0, 8'h0);
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ACK0 || ACK1) acks++;
        end
        chk("midrst_no_ack", 32'(acks), 32'd0);
        ref_valid[13'h0100] = 1'b0;

        // random single-outstanding traffic over a small address pool
        for (int n = 0; n < 40; n++) begin
            a = 13'(13'h0400 + $urandom_range(0, 15));
            txn_check(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                      8'($urandom_range(0, 255)), 0);
            tick();
        end

        chk("bus_conflicts", 32'(n_conflict), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
